// File: rtl/n4_b2_down_counter_pkg.sv
// Shared constants for the base-2 down-counter chain.
package n4_b2_down_counter_pkg;

  localparam int N_DIGITS = 4;

endpackage

// File: rtl/n4_b2_down_counter_cell.sv
// One base-2 down-counter digit: loads d, toggles on borrow-in, passes borrow on.
module b2_down_counter (
  input  logic clock,
  input  logic reset,
  input  logic ei,
  input  logic ld,
  input  logic d,
  output logic eu,
  output logic q
);

  // A digit only borrows onward when it is 0, enabled, and not being loaded.
  assign eu = ei & ~q & ~ld;

  // NOTE: non-blocking assignment keeps every digit sampling the pre-edge chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= 1'b0;
    end else if (ld) begin
      q <= d;
    end else if (ei) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/n4_b2_down_counter.sv
// N-digit base-2 down counter built from a chain of single-digit cells.
module n4_b2_down_counter
  import n4_b2_down_counter_pkg::*;
#(
  parameter int N = N_DIGITS
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ei,
  input  logic         ld,
  input  logic [N-1:0] d3_d0,
  output logic [N-1:0] q3_q0,
  output logic         eu,
  output logic         z
);

  // borrow[i] is the enable into digit i; borrow[N] leaves the block.
  logic [N:0] borrow;

  assign borrow[0] = ei;

  for (genvar i = 0; i < N; i++) begin : g_digit
    b2_down_counter u_digit (
      .clock (clock),
      .reset (reset),
      .ei    (borrow[i]),
      .ld    (ld),
      .d     (d3_d0[i]),
      .eu    (borrow[i+1]),
      .q     (q3_q0[i])
    );
  end

  assign eu = borrow[N];
  assign z  = ~|q3_q0;

endmodule

// File: doc/n4_b2_down_counter.md
Name: n4_b2_down_counter

Overview:
- 4-digit base-2 down counter: a chain of one-digit base-2 down-counter cells linked by a borrow (enable) chain, mirroring the team's up-counter chain in the decrement direction.
- Decrements by one per clock while enable-in `ei` is high.
- Raises borrow-out `eu` when a decrement from 0000 wraps to 1111; `eu` cascades into the `ei` of a more significant counter.
- Adds a synchronous parallel load so the block can act as a reloadable timer/countdown.

Parameters:
- N, 4, number of base-2 digits. Default 4; the behaviour below is written for N=4 and must hold for any N>=1.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- ei  input  1  enable-in / borrow request: decrement by one this cycle.
- ld  input  1  synchronous parallel load strobe.
- d3_d0  input  N  parallel load value.
- q3_q0  output  N  current count; q3_q0[0] is the LSB digit.
- eu  output  1  borrow-out to the next counter stage (combinational).
- z  output  1  zero flag: 1 when q3_q0 == 0 (combinational from state).

Behaviour:
- Reset: reset=1 at a rising edge gives q3_q0=0000 next cycle, so z=1. `eu` follows its equation (eu=ei while q==0).
- Priority at each rising edge: reset > ld > ei > hold.
- Load: ld=1 (reset=0) gives q3_q0 <= d3_d0, and `ei` is ignored that cycle. `eu` is forced to 0 whenever ld=1.
- Decrement: ld=0, ei=1 gives q3_q0 <= q3_q0 - 1 mod 2^N. Latency is 1 cycle; the new value is visible after the edge.
- Hold: ld=0, ei=0 keeps q3_q0 unchanged.
- Borrow chain (per digit i):
  - ei_0 = ei.
  - eu_i = ei_i & ~q_i & ~ld.
  - ei_(i+1) = eu_i.
  - Block eu = eu_(N-1).
  - Hence eu = ei & ~ld & (q3_q0 == 0). It is purely combinational with no register delay, so stages can be cascaded in the same cycle.
- Digit cell update: ld gives q_i <= d_i. Otherwise ei_i gives q_i <= ~q_i, else hold.
- Wrap-around: ei=1 at q=0000 gives next q=1111, with eu=1 during that cycle only.
- Simultaneous ld and ei at q=0000: load wins, eu=0, q=d3_d0.
- Reset mid-count (including reset with ld=1): q=0000 next cycle and the load is discarded.
- No internal state other than the N digit flops; no FSM beyond per-digit toggle.
- z = (q3_q0 == 0), independent of ei and ld.

Decomposition:
- No shared package needed. Optional constant N_DIGITS=4 in the team's common counter constants file.
- One sub-module: b2_down_counter, a single-digit cell.
  - Ports: clock, reset, ei, ld, d, eu, q.
  - Logic: eu = ei & ~q & ~ld. Toggle on ei, load on ld, sync active-high reset to 0.
- Top level: N instances chained eu to ei, with a generate loop or explicit instances for N=4.

Test Plan:
- Reset: assert reset 1 cycle with ei=1, ld=1, d=1010 -> q=0000, z=1; then ei=1 one cycle -> q=1111, z=0.
- Free countdown: load 0011, then ei=1 for 4 cycles -> q=0010, 0001, 0000, 1111. eu=1 only in the cycle where q=0000 and ei=1; z=1 only while q=0000.
- Hold: q=0101, ei=0 for 3 cycles -> q stays 0101, eu=0.
- Load vs. decrement: q=0000, ei=1, ld=1, d=1001 -> eu=0 that cycle, next q=1001 (not 1111).
- Cascade: two instances, low.eu driving high.ei; load low=0000, high=0001, ei=1 -> next low=1111, high=0000 in the same edge.
- Exhaustive: from 1111 with ei=1 for 16 cycles -> q sequence 1110..0000, 1111. Each value is checked against a reference model (q-1 mod 16), and eu is asserted exactly once.
